// File: rtl/uart_frame_tx_if.sv
// Frame handshake between the frame builder and the UART frame transmitter.
// Master drives the request/data; slave returns status and the serial line.
interface uart_frame_tx_if #(
  parameter int unsigned FRAME_BYTES = 11
) ();
  logic                     start_i;
  logic [8*FRAME_BYTES-1:0] frame_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     tx_o;

  modport master (
    output start_i,
    output frame_i,
    input  busy_o,
    input  done_o,
    input  tx_o
  );

  modport slave (
    input  start_i,
    input  frame_i,
    output busy_o,
    output done_o,
    output tx_o
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Serializes one fixed-length frame as back-to-back 8N1 characters, MSB byte first,
// optionally replacing the final byte with an 8-bit running sum of the others.
module uart_frame_tx #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FRAME_BYTES = 11,
  parameter bit          APPEND_CSUM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_frame_tx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned FW           = 8 * FRAME_BYTES;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [IDX_W-1:0] byte_q;
  // Holds bytes 1..FRAME_BYTES-1; byte 0 goes straight into cur_q at acceptance.
  logic [FW-9:0]    shreg_q;
  logic [7:0]       cur_q;
  logic [7:0]       acc_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic       baud_end;
  logic       last_byte;
  logic       next_is_last;
  logic [7:0] next_byte;

  assign baud_end     = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_byte    = (byte_q == IDX_W'(FRAME_BYTES - 1));
  assign next_is_last = (byte_q == IDX_W'(FRAME_BYTES - 2));
  assign next_byte    = shreg_q[FW-9 -: 8];

  assign bus.tx_o   = tx_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (bus.start_i) begin
            shreg_q <= bus.frame_i[FW-9:0];
            cur_q   <= bus.frame_i[FW-1 -: 8];
            acc_q   <= bus.frame_i[FW-1 -: 8];
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (last_byte) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_q  <= byte_q + IDX_W'(1);
              shreg_q <= {shreg_q[FW-17:0], 8'h00};
              cur_q   <= (APPEND_CSUM && next_is_last) ? acc_q : next_byte;
              if (!next_is_last) begin
                acc_q <= acc_q + next_byte;
              end
              tx_q    <= 1'b0;
              state_q <= StStart;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: two instances (checksum appended / verbatim) share
// stimulus; each frame's tx waveform is captured per cycle and checked against expected bytes.
module tb_uart_frame_tx;

  localparam int unsigned NB   = 11;
  localparam int unsigned CPB  = 4;
  localparam int unsigned FLEN = NB * 10 * CPB;  // 440

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8*NB-1:0] frame = '0;

  int tests = 0;
  int fails = 0;

  logic cap_tx_a [0:FLEN];
  logic cap_tx_b [0:FLEN];
  logic cap_busy [0:FLEN];
  logic cap_done [0:FLEN];

  uart_frame_tx_if #(.FRAME_BYTES(NB)) ifa ();
  uart_frame_tx_if #(.FRAME_BYTES(NB)) ifb ();

  assign ifa.start_i = start;
  assign ifa.frame_i = frame;
  assign ifb.start_i = start;
  assign ifb.frame_i = frame;

  uart_frame_tx #(
    .CLK_HZ(1000000), .BAUD(250000), .FRAME_BYTES(NB), .APPEND_CSUM(1'b1)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  uart_frame_tx #(
    .CLK_HZ(1000000), .BAUD(250000), .FRAME_BYTES(NB), .APPEND_CSUM(1'b0)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] f, input int k,
                                          input bit csum);
    logic [7:0] s;
    if (k < NB - 1 || !csum) return f[8*NB-1 - 8*k -: 8];
    s = 8'h00;
    for (int i = 0; i < NB - 1; i++) s = s + f[8*NB-1 - 8*i -: 8];
    return s;
  endfunction

  // mode 0: plain; 1: pulse start with alt data mid-frame; 2: scramble frame_i every cycle.
  task automatic run_frame(input logic [8*NB-1:0] f, input int mode,
                           input logic [8*NB-1:0] alt);
    start = 1'b1;
    frame = f;
    @(posedge clk);
    #1 start = 1'b0;
    for (int o = 0; o <= FLEN; o++) begin
      @(negedge clk);
      cap_tx_a[o] = ifa.tx_o;
      cap_tx_b[o] = ifb.tx_o;
      cap_busy[o] = ifa.busy_o;
      cap_done[o] = ifa.done_o;
      if (mode == 1 && o == 100) begin
        start = 1'b1;
        frame = alt;
      end
      if (mode == 1 && o == 101) start = 1'b0;
      if (mode == 2) frame = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic check_frame(input string tag, input logic [8*NB-1:0] f);
    int bad_a = 0, bad_b = 0, bad_busy = 0, bad_done = 0;
    logic ea, eb;
    logic [7:0] da, db;
    for (int o = 0; o < FLEN; o++) begin
      int k = o / (10 * CPB);
      int p = (o % (10 * CPB)) / CPB;
      if (p == 0) begin
        ea = 1'b0; eb = 1'b0;
      end else if (p == 9) begin
        ea = 1'b1; eb = 1'b1;
      end else begin
        ea = exp_byte(f, k, 1'b1) >> (p - 1);
        eb = exp_byte(f, k, 1'b0) >> (p - 1);
      end
      if (cap_tx_a[o] !== ea) bad_a++;
      if (cap_tx_b[o] !== eb) bad_b++;
      if (cap_busy[o] !== 1'b1) bad_busy++;
      if (cap_done[o] !== 1'b0) bad_done++;
    end
    chk({tag, " wave_a_bad_cycles"}, bad_a, 0);
    chk({tag, " wave_b_bad_cycles"}, bad_b, 0);
    chk({tag, " busy_low_cycles"}, bad_busy, 0);
    chk({tag, " early_done_cycles"}, bad_done, 0);
    chk({tag, " done_at_440"}, {31'd0, cap_done[FLEN]}, 1);
    chk({tag, " busy_at_440"}, {31'd0, cap_busy[FLEN]}, 0);
    chk({tag, " tx_at_440"}, {31'd0, cap_tx_a[FLEN]}, 1);
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < 8; j++) begin
        da[j] = cap_tx_a[k * 10 * CPB + (j + 1) * CPB + 2];
        db[j] = cap_tx_b[k * 10 * CPB + (j + 1) * CPB + 2];
      end
      chk($sformatf("%s byte_a%0d", tag, k), {24'd0, da}, {24'd0, exp_byte(f, k, 1'b1)});
      chk($sformatf("%s byte_b%0d", tag, k), {24'd0, db}, {24'd0, exp_byte(f, k, 1'b0)});
    end
  endtask

  initial begin
    logic [8*NB-1:0] f1, f2, f3, f4, f5, f6, f7;
    int done_seen;
    f1 = 88'hBAFD_0000000000000003_77;
    f2 = 88'hBAFD_FFFFFFFFFFFFFFFF_5A;
    f3 = 88'h1234_0102030405060708_99;
    f4 = 88'hA55A_F0E1D2C3B4A59687_3C;
    f5 = 88'h00FF_8040201008040201_C3;
    f6 = 88'hDEAD_BEEFCAFEF00D1234_11;
    f7 = 88'h0F0F_AAAA5555AAAA5555_E7;

    repeat (3) @(negedge clk);
    chk("reset tx_a", {31'd0, ifa.tx_o}, 1);
    chk("reset tx_b", {31'd0, ifb.tx_o}, 1);
    chk("reset busy", {31'd0, ifa.busy_o}, 0);
    chk("reset done", {31'd0, ifa.done_o}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame: BA FD 00x7 03, checksum BA.
    run_frame(f1, 0, '0);
    check_frame("f1", f1);
    chk("f1 csum_literal", {31'd0, cap_tx_a[10 * 10 * CPB + 1 * CPB + 2]}, 0);
    chk("f1 csum_bit1", {31'd0, cap_tx_a[10 * 10 * CPB + 2 * CPB + 2]}, 1);

    // Checksum wrap: BA+FD+8*FF = AF; verbatim instance sends 5A.
    repeat (5) @(negedge clk);
    run_frame(f2, 0, '0);
    check_frame("f2", f2);

    // Start pulse mid-frame is ignored; next frame starts in the done cycle.
    repeat (5) @(negedge clk);
    run_frame(f3, 1, f6);
    check_frame("f3", f3);
    run_frame(f4, 0, '0);
    check_frame("f4_b2b", f4);

    // frame_i scrambled every cycle after acceptance.
    repeat (5) @(negedge clk);
    run_frame(f5, 2, '0);
    check_frame("f5", f5);

    // Reset during byte 4.
    repeat (5) @(negedge clk);
    start = 1'b1;
    frame = f6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4 * 10 * CPB + 10) @(negedge clk);
    chk("pre_reset busy", {31'd0, ifa.busy_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset tx_a", {31'd0, ifa.tx_o}, 1);
    chk("mid_reset tx_b", {31'd0, ifb.tx_o}, 1);
    chk("mid_reset busy", {31'd0, ifa.busy_o}, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.done_o === 1'b1 || ifb.done_o === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.done_o === 1'b1 || ifb.done_o === 1'b1) done_seen++;
    end
    chk("reset no_done", done_seen, 0);
    chk("post_reset tx", {31'd0, ifa.tx_o}, 1);
    run_frame(f7, 0, '0);
    check_frame("f7", f7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
